// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register built as a 2-entry skid buffer.
// The zero and overflow flags are computed when an entry is captured.
// On a trapping overflow, the register and memory write enables are cleared.
// in_ready and out_valid are decoded only from the registered occupancy.
// So there is no combinational path from in_valid or out_ready.
module ex_mem_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] alu_result,
  input  logic         a_msb,
  input  logic         b_msb,
  input  logic         bin,
  input  logic [W-1:0] rt_data,
  input  logic [4:0]   rd_addr,
  input  logic [3:0]   ctl_in,
  input  logic         chk_ovf,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [W-1:0] out_rt,
  output logic [4:0]   out_rd,
  output logic [3:0]   out_ctl,
  output logic         out_zero,
  output logic         out_ovf
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Head slot drives out_* directly; skid slot holds the second entry.
  logic [W-1:0] head_result_reg, skid_result_reg;
  logic [W-1:0] head_rt_reg, skid_rt_reg;
  logic [4:0]   head_rd_reg, skid_rd_reg;
  logic [3:0]   head_ctl_reg, skid_ctl_reg;
  logic         head_zero_reg, skid_zero_reg;
  logic         head_ovf_reg, skid_ovf_reg;

  logic load_head_in;    // incoming entry goes straight to the head
  logic load_skid_in;    // incoming entry parks in the skid slot
  logic load_head_skid;  // skid entry advances to the head

  // Flags and control as they will be stored for the incoming instruction.
  logic       cap_zero;
  logic       cap_ovf;
  logic [3:0] cap_ctl;

  // Signed overflow: operands agree in sign, and the result sign differs.
  // B's sign is taken after the subtract inversion.
  assign cap_zero = (alu_result == '0);
  assign cap_ovf  = chk_ovf && (a_msb == (b_msb ^ bin)) && (alu_result[W-1] != a_msb);
  assign cap_ctl  = {ctl_in[3] & ~cap_ovf, ctl_in[2:1], ctl_in[0] & ~cap_ovf};

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);

  assign out_result = head_result_reg;
  assign out_rt     = head_rt_reg;
  assign out_rd     = head_rd_reg;
  assign out_ctl    = head_ctl_reg;
  assign out_zero   = head_zero_reg;
  assign out_ovf    = head_ovf_reg;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Next occupancy and slot-load selects; flush overrides every transfer.
  always_comb begin
    state_next     = state_reg;
    load_head_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_head_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_valid) begin
            load_head_in = 1'b1;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            load_head_in = 1'b1;
            state_next   = ONE;
          end else if (in_valid) begin
            load_skid_in = 1'b1;
            state_next   = FULL;
          end else if (out_ready) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            load_head_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Head slot: loads only when a new entry becomes the head.
  // It therefore holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_result_reg <= '0;
      head_rt_reg     <= '0;
      head_rd_reg     <= '0;
      head_ctl_reg    <= '0;
      head_zero_reg   <= 1'b0;
      head_ovf_reg    <= 1'b0;
    end else if (load_head_in) begin
      head_result_reg <= alu_result;
      head_rt_reg     <= rt_data;
      head_rd_reg     <= rd_addr;
      head_ctl_reg    <= cap_ctl;
      head_zero_reg   <= cap_zero;
      head_ovf_reg    <= cap_ovf;
    end else if (load_head_skid) begin
      head_result_reg <= skid_result_reg;
      head_rt_reg     <= skid_rt_reg;
      head_rd_reg     <= skid_rd_reg;
      head_ctl_reg    <= skid_ctl_reg;
      head_zero_reg   <= skid_zero_reg;
      head_ovf_reg    <= skid_ovf_reg;
    end
  end

  // Skid slot: captures the second entry while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_result_reg <= '0;
      skid_rt_reg     <= '0;
      skid_rd_reg     <= '0;
      skid_ctl_reg    <= '0;
      skid_zero_reg   <= 1'b0;
      skid_ovf_reg    <= 1'b0;
    end else if (load_skid_in) begin
      skid_result_reg <= alu_result;
      skid_rt_reg     <= rt_data;
      skid_rd_reg     <= rd_addr;
      skid_ctl_reg    <= cap_ctl;
      skid_zero_reg   <= cap_zero;
      skid_ovf_reg    <= cap_ovf;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid.
// It applies a table of capture vectors, then runs directed back-pressure,
// flush and asynchronous-reset sequences.
// It ends with a random run compared against a FIFO scoreboard.
module tb_ex_mem_skid;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_result;
  logic         a_msb, b_msb, bin;
  logic [W-1:0] rt_data;
  logic [4:0]   rd_addr;
  logic [3:0]   ctl_in;
  logic         chk_ovf;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result, out_rt;
  logic [4:0]   out_rd;
  logic [3:0]   out_ctl;
  logic         out_zero, out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_skid #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .a_msb(a_msb), .b_msb(b_msb), .bin(bin),
    .rt_data(rt_data), .rd_addr(rd_addr), .ctl_in(ctl_in), .chk_ovf(chk_ovf),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rt(out_rt), .out_rd(out_rd),
    .out_ctl(out_ctl), .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        a, b, bn, chk;
    logic [3:0]  ctl;
    logic [3:0]  e_ctl;
    logic        e_zero;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic        zero;
    logic        ovf;
  } ent_t;

  vec_t vecs[8];
  ent_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] res, input logic [31:0] rt, input logic [4:0] rd,
                       input logic a, input logic b, input logic bn, input logic chk,
                       input logic [3:0] ctl);
    alu_result = res; rt_data = rt; rd_addr = rd;
    a_msb = a; b_msb = b; bin = bn; chk_ovf = chk; ctl_in = ctl;
  endtask

  // Independent golden model of the capture arithmetic.
  function automatic ent_t model(input logic [31:0] res, input logic [31:0] rt, input logic [4:0] rd,
                                 input logic a, input logic b, input logic bn, input logic chk,
                                 input logic [3:0] ctl);
    ent_t e;
    logic ov;
    ov = chk && (a == (b ^ bn)) && (res[31] != a);
    e.res = res; e.rt = rt; e.rd = rd; e.zero = (res == 32'd0); e.ovf = ov;
    e.ctl = ov ? (ctl & 4'b0110) : ctl;
    return e;
  endfunction

  initial begin
    //          res            rt             rd     a     b     bn    chk   ctl      e_ctl    zero  ovf
    vecs[0] = '{32'h0000_0005, 32'h1111_0000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h2222_0000, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 4'b0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h3333_0000, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h4444_0000, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b0110, 1'b1, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'h5555_0000, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0110, 1'b0, 1'b1};
    vecs[5] = '{32'h7FFF_FFFF, 32'h6666_0000, 5'd6,  1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0010, 32'h7777_0000, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 4'b1010, 4'b0010, 1'b0, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'h8888_0000, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101, 4'b1101, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Reset state.
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_ctl", {28'd0, out_ctl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Capture vectors: streaming with out_ready=1 shows each entry one cycle later.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].res, vecs[i].rt, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].bn,
            vecs[i].chk, vecs[i].ctl);
      in_valid = 1'b1;
      @(negedge clk);
      $display("vec %0d: result=%h zero=%b ovf=%b ctl=%b", i, out_result, out_zero, out_ovf, out_ctl);
      check("vec_valid", {31'd0, out_valid}, 32'd1);
      check("vec_result", out_result, vecs[i].res);
      check("vec_rt", out_rt, vecs[i].rt);
      check("vec_rd", {27'd0, out_rd}, {27'd0, vecs[i].rd});
      check("vec_ctl", {28'd0, out_ctl}, {28'd0, vecs[i].e_ctl});
      check("vec_zero", {31'd0, out_zero}, {31'd0, vecs[i].e_zero});
      check("vec_ovf", {31'd0, out_ovf}, {31'd0, vecs[i].e_ovf});
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Back-pressure: A and B fill the buffer, C is held off, then all drain in order.
    out_ready = 1'b0;
    drive(32'hA, 32'h0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000); in_valid = 1'b1;
    @(negedge clk);
    check("bp_A_head", out_result, 32'hA);
    check("bp_ready_one", {31'd0, in_ready}, 32'd1);
    drive(32'hB, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    @(negedge clk);
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    check("bp_A_stable", out_result, 32'hA);
    drive(32'hC, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    @(negedge clk);
    check("bp_A_held", out_result, 32'hA);
    check("bp_C_held_off", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    $display("bp out: %h", out_result);
    check("bp_B_second", out_result, 32'hB);
    check("bp_ready_after", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    $display("bp out: %h", out_result);
    check("bp_C_third", out_result, 32'hC);
    check("bp_C_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL, with a concurrent in_valid that must be dropped.
    out_ready = 1'b0;
    drive(32'h11, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000); in_valid = 1'b1;
    @(negedge clk);
    drive(32'h22, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    @(negedge clk);
    check("fl_full", {31'd0, in_ready}, 32'd0);
    drive(32'h33, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    $display("flush: out_valid=%b in_ready=%b", out_valid, in_ready);
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl_no_ghost", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    drive(32'h44, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000); in_valid = 1'b1;
    @(negedge clk);
    drive(32'h55, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: out_valid=%b out_result=%h", out_valid, out_result);
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_result", out_result, 32'd0);
    check("ar_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    drive(32'h66, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_fresh", out_result, 32'h66);
    check("ar_fresh_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("ar_drained", {31'd0, out_valid}, 32'd0);

    // Random traffic against a FIFO scoreboard.
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [31:0] r_res, r_rt;
      logic [4:0]  r_rd;
      logic        r_a, r_b, r_bn, r_chk;
      logic [3:0]  r_ctl;
      logic        pop, push;
      check("rnd_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      check("rnd_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (q.size() > 0 && out_valid) begin
        check("rnd_result", out_result, q[0].res);
        check("rnd_rt", out_rt, q[0].rt);
        check("rnd_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        check("rnd_ctl", {28'd0, out_ctl}, {28'd0, q[0].ctl});
        check("rnd_zero", {31'd0, out_zero}, {31'd0, q[0].zero});
        check("rnd_ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
      end
      r_res = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      r_rt = $urandom;
      r_rd = 5'($urandom);
      r_a = 1'($urandom); r_b = 1'($urandom); r_bn = 1'($urandom); r_chk = 1'($urandom);
      r_ctl = 4'($urandom);
      drive(r_res, r_rt, r_rd, r_a, r_b, r_bn, r_chk, r_ctl);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      if (flush) begin
        q.delete();
      end else begin
        pop  = (q.size() > 0) && out_ready;
        push = in_valid && (q.size() < 2);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(model(r_res, r_rt, r_rd, r_a, r_b, r_bn, r_chk, r_ctl));
      end
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 SHALL have parameter W, default 32, giving ALU result / store-data width.
REQ-002 clk  in  1  single clock; all state rises on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  EX stage presents a valid instruction.
REQ-005 in_ready  out  1  stage can accept; equals (occupancy < 2).
REQ-006 alu_result  in  W  result bus assembled from the per-bit ALU slices.
REQ-007 a_msb, b_msb, bin  in  1 each  MSB of ALU operand A, MSB of operand B before inversion, and the subtract flag.
REQ-008 rt_data  in  W  store data.
REQ-009 rd_addr  in  5  destination register.
REQ-010 ctl_in  in  4  {reg_write, mem_to_reg, mem_read, mem_write}.
REQ-011 chk_ovf  in  1  instruction traps on signed overflow (add/sub, not addu/subu).
REQ-012 flush  in  1  discard all held and incoming entries.
REQ-013 out_valid  out  1  MEM stage entry valid.
REQ-014 out_ready  in  1  MEM stage accepts.
REQ-015 out_result, out_rt  out  W each  registered alu_result, rt_data.
REQ-016 out_rd  out  5; out_ctl  out  4; out_zero  out  1; out_ovf  out  1.

Function
REQ-017 SHALL be a 2-entry skid buffer: state EMPTY (0), ONE (1), FULL (2); entries are registers, no combinational path in_valid->out_valid or out_ready->in_ready.
REQ-018 Input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-019 Latency: an entry accepted in an EMPTY cycle SHALL appear at outputs the next cycle.
REQ-020 Transitions: EMPTY+in->ONE; ONE+in only->FULL; ONE+out only->EMPTY; ONE+in+out->ONE (new entry to head); FULL+out->ONE (skid entry moves to head); FULL with in_valid is not accepted.
REQ-021 Order SHALL be strictly FIFO; out_* SHALL always show the head entry and stay stable while out_valid && !out_ready.
REQ-022 Zero flag computed at capture: zero = (alu_result == 0).
REQ-023 Overflow computed at capture: ovf = (a_msb == (b_msb ^ bin)) && (alu_result[W-1] != a_msb); stored ovf = ovf && chk_ovf.
REQ-024 When stored ovf is 1, captured reg_write and mem_write SHALL be forced to 0; other ctl bits unchanged.
REQ-025 flush SHALL, next edge, set state EMPTY and out_valid 0; an in_valid in the flush cycle SHALL be dropped; flush dominates all transfers.
REQ-026 Data registers of an empty slot are don't-care but SHALL not change out_* while out_valid is 1.
REQ-027 Occupancy SHALL never exceed 2 nor underflow below 0; out_ready with EMPTY has no effect.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force state EMPTY, out_valid 0, in_ready 1, and all out_* data/flag/ctl registers 0.
REQ-029 Reset deassertion SHALL be synchronised by the integrator; the block accepts in_valid from the first edge after rst_n high.
REQ-030 Reset mid-transfer SHALL discard both entries with no partial output.

Verification
REQ-031 Single pass: in alu_result=0x0000_0005, ctl=1000, out_ready=1 -> next cycle out_valid=1, out_result=5, out_zero=0, out_ctl=1000.
REQ-032 Zero/overflow: a_msb=0,b_msb=0,bin=0,alu_result=0x8000_0000,chk_ovf=1,ctl=1001 -> out_ovf=1, out_ctl=0000; same with chk_ovf=0 -> out_ovf=0, out_ctl=1001; alu_result=0 -> out_zero=1.
REQ-033 Back-pressure: out_ready=0, push A,B -> in_ready=0 after B, C held off; raise out_ready -> A then B then C in order, no loss or duplication.
REQ-034 Flush: FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entry never appears.
REQ-035 Async reset: drop rst_n mid-cycle while FULL -> out_valid=0, out_result=0 before next clk edge; resume after release with fresh push.
REQ-036 Random: 10k cycles random in_valid/out_ready/flush vs scoreboard -> order, zero and ovf flags match golden model.
